// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcode, state and nibble-width definitions for the
//                4-bit ALU family and the multi-cycle nibble sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Width of one ALU slice
    localparam int NIB_W = 4;

    // Opcode set shared with the existing 4-bit ALU
    localparam logic [1:0] OP_NOTB = 2'd0;
    localparam logic [1:0] OP_AND  = 2'd1;
    localparam logic [1:0] OP_OR   = 2'd2;
    localparam logic [1:0] OP_ADD  = 2'd3;

    // Sequencer state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_nibble_slice.sv
`default_nettype none
// ============================================================================
//  Module      : alu_nibble_slice
//  Description : Combinational 4-bit ALU slice with carry in/out. Carry is
//                only meaningful for ADD; other ops report cout = 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_nibble_slice
    import alu_pkg::*;
(
    input  logic [1:0]       op,
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] y,
    output logic             cout
);

    // Arithmetic is carried out one bit wider than the nibble so the carry
    // falls out naturally in the top bit.
    logic [NIB_W:0] w_sum;

    assign w_sum = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};

    // Select the nibble result and carry for the requested operation
    always_comb begin
        y    = '0;
        cout = 1'b0;
        case (op)
            OP_NOTB: y = ~b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_ADD: begin
                y    = w_sum[NIB_W-1:0];
                cout = w_sum[NIB_W];
            end
            default: y = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_nibble_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_nibble_sequencer
//  Description : Wide-operand ALU front end. Accepts one WIDTH-bit request
//                per handshake, evaluates it one nibble per clock (LSB first)
//                through a single alu_nibble_slice with carry chaining, and
//                presents the result and final carry on a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_nibble_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NNIB  = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             busy
);

    localparam int              CNT_W    = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NNIB - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic [1:0]       r_op;
    // Operands shift right one nibble per RUN cycle, so the slice always
    // consumes the low nibble.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic [NIB_W-1:0] w_y;
    logic             w_cout;

    alu_nibble_slice u_slice (
        .op   (r_op),
        .a    (r_a[NIB_W-1:0]),
        .b    (r_b[NIB_W-1:0]),
        .cin  (r_carry),
        .y    (w_y),
        .cout (w_cout)
    );

    // Handshake FSM, nibble counter, operand/result registers and carry chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_op        <= OP_NOTB;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_op       <= in_op;
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_carry    <= 1'b0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    for (int i = 0; i < NNIB; i++) begin
                        if (r_cnt == CNT_W'(i)) begin
                            r_result[i*NIB_W +: NIB_W] <= w_y;
                        end
                    end
                    // The slice already reports cout = 0 for non-ADD ops
                    r_carry <= w_cout;
                    r_a     <= r_a >> NIB_W;
                    r_b     <= r_b >> NIB_W;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST_NIB) begin
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_result = r_result;
    assign out_carry  = r_carry;
    assign busy       = r_busy;

endmodule
`default_nettype wire
